// File: rtl/cpu_decode_pkg.sv
// Shared types for the fetch->decode queue: opcodes, instruction formats,
// field positions and instruction classes.
package cpu_decode_pkg;

  localparam int unsigned DST_MSB  = 24;
  localparam int unsigned DST_LSB  = 20;
  localparam int unsigned SRC2_MSB = 14;
  localparam int unsigned SRC2_LSB = 10;
  localparam int unsigned IMM_W    = 15;

  typedef enum logic [6:0] {
    OP_ADD      = 7'h00,
    OP_SUB      = 7'h01,
    OP_MUL      = 7'h02,
    OP_LDB      = 7'h10,
    OP_LDW      = 7'h11,
    OP_STB      = 7'h12,
    OP_STW      = 7'h13,
    OP_MOV      = 7'h14,
    OP_BEQ      = 7'h30,
    OP_JUMP     = 7'h31,
    OP_TLBWRITE = 7'h32,
    OP_IRET     = 7'h33
  } opcode_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_MOV,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_SYS,
    CLS_ILLEGAL
  } instr_class_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] dst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [9:0] unused;
  } r_instr_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [14:0] imm;
  } m_instr_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] off_hi;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [9:0] off_lo;
  } b_instr_t;

  typedef union packed {
    r_instr_t r;
    m_instr_t m;
    b_instr_t b;
  } instr_u;

  function automatic instr_class_t classify(input logic [6:0] op);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: cls = CLS_ALU;
      OP_LDB, OP_LDW:         cls = CLS_LOAD;
      OP_STB, OP_STW:         cls = CLS_STORE;
      OP_MOV:                 cls = CLS_MOV;
      OP_BEQ:                 cls = CLS_BRANCH;
      OP_JUMP:                cls = CLS_JUMP;
      OP_TLBWRITE, OP_IRET:   cls = CLS_SYS;
      default:                cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_predecode.sv
// Combinational pre-decode of one instruction word: register fields,
// sign-extended immediate, operand-use flags and illegal-opcode detection.
module cpu_predecode
  import cpu_decode_pkg::*;
#(
  parameter int unsigned VADDR_WIDTH = 32,
  parameter int unsigned EXC_WIDTH   = 2
) (
  input  logic [31:0]            instr,
  input  logic [EXC_WIDTH-1:0]   exc,
  output logic [6:0]             opcode,
  output logic [4:0]             dst,
  output logic [4:0]             src1,
  output logic [4:0]             src2,
  output logic [VADDR_WIDTH-1:0] imm,
  output logic                   rd_src1,
  output logic                   rd_src2,
  output logic                   wr_dst,
  output logic                   illegal
);

  instr_u             iw;
  instr_class_t       cls;
  logic [IMM_W-1:0]   imm_raw;
  logic               use_imm;

  assign iw  = instr;
  assign cls = classify(iw.r.opcode);

  // Classify the word and derive fields/flags; an exception masks the flags.
  always_comb begin
    opcode  = iw.r.opcode;
    dst     = iw.r.dst;
    src1    = iw.r.src1;
    src2    = instr[SRC2_MSB:SRC2_LSB];
    rd_src1 = 1'b0;
    rd_src2 = 1'b0;
    wr_dst  = 1'b0;
    illegal = 1'b0;
    use_imm = 1'b0;
    imm_raw = iw.m.imm;
    case (cls)
      CLS_ALU: begin
        rd_src1 = 1'b1;
        rd_src2 = 1'b1;
        wr_dst  = 1'b1;
      end
      CLS_LOAD: begin
        rd_src1 = 1'b1;
        wr_dst  = 1'b1;
        use_imm = 1'b1;
      end
      CLS_STORE: begin
        // Store data travels in the dst field.
        src2    = instr[DST_MSB:DST_LSB];
        rd_src1 = 1'b1;
        rd_src2 = 1'b1;
        use_imm = 1'b1;
      end
      CLS_MOV: begin
        wr_dst  = 1'b1;
        use_imm = 1'b1;
      end
      CLS_BRANCH: begin
        rd_src1 = 1'b1;
        rd_src2 = 1'b1;
        use_imm = 1'b1;
        imm_raw = {iw.b.off_hi, iw.b.off_lo};
      end
      CLS_JUMP: begin
        rd_src1 = 1'b1;
        use_imm = 1'b1;
        imm_raw = {iw.b.off_hi, iw.b.off_lo};
      end
      CLS_SYS: begin
        if (iw.r.opcode == OP_TLBWRITE) begin
          rd_src1 = 1'b1;
          rd_src2 = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (exc != '0) begin
      rd_src1 = 1'b0;
      rd_src2 = 1'b0;
      wr_dst  = 1'b0;
      illegal = 1'b0;
    end
    imm = use_imm ? {{(VADDR_WIDTH-IMM_W){imm_raw[IMM_W-1]}}, imm_raw} : '0;
  end

endmodule

// File: rtl/cpu_decode_queue.sv
// DEPTH-entry fetch->decode FIFO with valid/ready on both sides, flush,
// and pre-decode of the head entry.
module cpu_decode_queue
  import cpu_decode_pkg::*;
#(
  parameter int unsigned VADDR_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned EXC_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VADDR_WIDTH-1:0]   in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [EXC_WIDTH-1:0]     in_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VADDR_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [EXC_WIDTH-1:0]     out_exc,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_dst,
  output logic [4:0]               out_src1,
  output logic [4:0]               out_src2,
  output logic [VADDR_WIDTH-1:0]   out_imm,
  output logic                     out_rd_src1,
  output logic                     out_rd_src2,
  output logic                     out_wr_dst,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [VADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [EXC_WIDTH-1:0]   exc_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;

  logic [6:0]             pd_opcode;
  logic [4:0]             pd_dst, pd_src1, pd_src2;
  logic [VADDR_WIDTH-1:0] pd_imm;
  logic                   pd_rd_src1, pd_rd_src2, pd_wr_dst, pd_illegal;

  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_count = count;

  // Entry storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      exc_mem[wr_ptr]   <= in_exc;
    end
  end

  // Pointers and occupancy; reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign out_exc   = exc_mem[rd_ptr];

  cpu_predecode #(
    .VADDR_WIDTH (VADDR_WIDTH),
    .EXC_WIDTH   (EXC_WIDTH)
  ) u_predecode (
    .instr   (out_instr),
    .exc     (out_exc),
    .opcode  (pd_opcode),
    .dst     (pd_dst),
    .src1    (pd_src1),
    .src2    (pd_src2),
    .imm     (pd_imm),
    .rd_src1 (pd_rd_src1),
    .rd_src2 (pd_rd_src2),
    .wr_dst  (pd_wr_dst),
    .illegal (pd_illegal)
  );

  assign out_opcode  = out_valid ? pd_opcode  : '0;
  assign out_dst     = out_valid ? pd_dst     : '0;
  assign out_src1    = out_valid ? pd_src1    : '0;
  assign out_src2    = out_valid ? pd_src2    : '0;
  assign out_imm     = out_valid ? pd_imm     : '0;
  assign out_rd_src1 = out_valid & pd_rd_src1;
  assign out_rd_src2 = out_valid & pd_rd_src2;
  assign out_wr_dst  = out_valid & pd_wr_dst;
  assign out_illegal = out_valid & pd_illegal;

endmodule

// File: tb/tb_cpu_decode_queue.sv
// Directed bench for cpu_decode_queue: decode table plus handshake,
// wrap, flush and reset sequences.
module tb_cpu_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, out_imm;
  logic [1:0]  in_exc, out_exc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_dst, out_src1, out_src2;
  logic        out_rd_src1, out_rd_src2, out_wr_dst, out_illegal;
  logic [2:0]  out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_decode_queue #(
    .VADDR_WIDTH (32),
    .INSTR_WIDTH (32),
    .DEPTH       (4),
    .EXC_WIDTH   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_exc      (in_exc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_exc     (out_exc),
    .out_opcode  (out_opcode),
    .out_dst     (out_dst),
    .out_src1    (out_src1),
    .out_src2    (out_src2),
    .out_imm     (out_imm),
    .out_rd_src1 (out_rd_src1),
    .out_rd_src2 (out_rd_src2),
    .out_wr_dst  (out_wr_dst),
    .out_illegal (out_illegal),
    .out_count   (out_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  exc;
    logic [31:0] imm;
    logic [4:0]  src2;
    logic        rd1;
    logic        rd2;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"},     32'(out_count), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_illegal"},   32'(out_illegal), 32'd0);
    check({tag, "_imm"},       out_imm, 32'd0);
  endtask

  initial begin
    //          instr                                          exc   imm            src2   rd1 rd2 wr  ill
    vecs[0]  = '{{7'h11, 5'd3, 5'd4, 15'h7FFF},                2'd0, 32'hFFFFFFFF, 5'h1F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{{7'h30, 5'h10, 5'd1, 5'd2, 10'd0},            2'd0, 32'hFFFFC000, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{{7'h7F, 25'd0},                               2'd0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{{7'h7F, 25'd0},                               2'd2, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{{7'h00, 5'd5, 5'd6, 5'd7, 10'h3FF},           2'd0, 32'h00000000, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{{7'h13, 5'd9, 5'd10, 15'h0010},               2'd0, 32'h00000010, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{{7'h14, 5'd1, 5'd0, 15'h4000},                2'd0, 32'hFFFFC000, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{{7'h31, 5'h0F, 5'd2, 5'd0, 10'h3FF},          2'd0, 32'h00003FFF, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{{7'h32, 5'd0, 5'd3, 5'd4, 10'd0},             2'd0, 32'h00000000, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{{7'h33, 25'd0},                               2'd0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{{7'h03, 5'd1, 5'd2, 5'd3, 10'd0},             2'd0, 32'h00000000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{{7'h10, 5'd7, 5'd8, 15'h0000},                2'd1, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_exc = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check_empty("reset");

    // Decode table: push one entry, inspect head next cycle, pop it.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(i); in_instr = vecs[i].instr; in_exc = vecs[i].exc;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i),   32'(out_valid),   32'd1);
      check($sformatf("v%0d_pc", i),      out_pc,           32'h1000 + 32'(i));
      check($sformatf("v%0d_instr", i),   out_instr,        vecs[i].instr);
      check($sformatf("v%0d_exc", i),     32'(out_exc),     32'(vecs[i].exc));
      check($sformatf("v%0d_opcode", i),  32'(out_opcode),  32'(vecs[i].instr[31:25]));
      check($sformatf("v%0d_imm", i),     out_imm,          vecs[i].imm);
      check($sformatf("v%0d_src2", i),    32'(out_src2),    32'(vecs[i].src2));
      check($sformatf("v%0d_rd1", i),     32'(out_rd_src1), 32'(vecs[i].rd1));
      check($sformatf("v%0d_rd2", i),     32'(out_rd_src2), 32'(vecs[i].rd2));
      check($sformatf("v%0d_wr", i),      32'(out_wr_dst),  32'(vecs[i].wr));
      check($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("v%0d_drained", i), 32'(out_count), 32'd0);
    end

    // Fill to full with consumer stalled; a fifth push must be refused.
    in_exc = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(i); in_instr = {7'h00, 25'(i)};
      step();
      q.push_back(32'h100 + 32'(i));
    end
    in_valid = 1'b0;
    check("full_count", 32'(out_count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_pc, 32'h100);
    in_valid = 1'b1; in_pc = 32'h104; in_instr = {7'h00, 25'd4};
    step();
    check("fifth_refused", 32'(out_count), 32'd4);
    // Full with both sides active: pop only.
    out_ready = 1'b1;
    step();
    void'(q.pop_front());
    check("full_pop_only", 32'(out_count), 32'd3);
    check("full_pop_head", out_pc, 32'h101);
    check("full_pop_ready", 32'(in_ready), 32'd1);

    // Stream across pointer wrap until 10 entries have gone in and all drained.
    begin
      int          pushed;
      logic        do_push, do_pop;
      logic [31:0] pc_now;
      pushed = 4;
      for (int cyc = 0; cyc < 60 && (pushed < 10 || q.size() != 0); cyc++) begin
        in_valid  = (pushed < 10);
        in_pc     = 32'h100 + 32'(pushed);
        in_instr  = {7'h00, 25'(pushed)};
        out_ready = ((cyc % 3) != 2);
        check("stream_count", 32'(out_count), 32'(q.size()));
        if (q.size() != 0) check("stream_pc", out_pc, q[0]);
        do_push = in_valid && (q.size() < 4);
        do_pop  = out_ready && (q.size() != 0);
        pc_now  = in_pc;
        step();
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back(pc_now);
          pushed++;
        end
      end
      check("stream_all_pushed", 32'(pushed), 32'd10);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_empty", 32'(out_count), 32'd0);

    // Flush with three queued and a concurrent push.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(i); in_instr = {7'h11, 25'(i)};
      step();
    end
    check("preflush_count", 32'(out_count), 32'd3);
    in_pc = 32'h2FF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush");
    in_valid = 1'b1; in_pc = 32'h300; in_instr = {7'h14, 5'd2, 5'd0, 15'h0005};
    step();
    in_valid = 1'b0;
    check("postflush_count", 32'(out_count), 32'd1);
    check("postflush_pc", out_pc, 32'h300);
    check("postflush_imm", out_imm, 32'h5);

    // Reset mid-stream, together with a flush and a push.
    in_valid = 1'b1; in_pc = 32'h301;
    step();
    check("prereset_count", 32'(out_count), 32'd2);
    rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
    step();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("midreset");
    in_valid = 1'b1; in_pc = 32'h400; in_instr = {7'h00, 25'd0};
    step();
    in_valid = 1'b0;
    check("postreset_pc", out_pc, 32'h400);
    check("postreset_count", 32'(out_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
